// File: rtl/dc_mem_pkg.sv
// Shared types and widths for the DC memory-side port.
package dc_mem_pkg;

    localparam int unsigned MAIN_ADDR_WIDTH = 16;
    localparam int unsigned WORD_WIDTH      = 32;
    localparam int unsigned NUM_DCS         = 4;
    localparam int unsigned CHOICE_WIDTH    = 2;

    typedef enum logic [1:0] {
        IDLE,
        WRITE_REQ,
        READ_REQ,
        READ_WAIT
    } dc_mem_state_t;

    typedef struct packed {
        logic                       reload;
        logic [CHOICE_WIDTH-1:0]    choice;
        logic [MAIN_ADDR_WIDTH-1:0] reload_address;
        logic                       write_out;
        logic [MAIN_ADDR_WIDTH-1:0] write_address;
        logic [WORD_WIDTH-1:0]      write_value;
    } dc_mem_cmd_t;

endpackage

// File: rtl/dc_forward_match.sv
// Flags every valid DC whose cached address equals an incoming store address.
module dc_forward_match
    import dc_mem_pkg::*;
(
    input  logic [NUM_DCS-1:0]                      dc_valid,
    input  logic [NUM_DCS-1:0][MAIN_ADDR_WIDTH-1:0] dc_addrs,
    input  logic [MAIN_ADDR_WIDTH-1:0]              write_address,
    output logic [NUM_DCS-1:0]                      fwd_mask_c
);

    always_comb begin
        fwd_mask_c = '0;
        for (int unsigned i = 0; i < NUM_DCS; i++) begin
            fwd_mask_c[i] = dc_valid[i] && (dc_addrs[i] == write_address);
        end
    end

endmodule

// File: rtl/dc_mem_port.sv
// Services DC reload/write-out commands against main memory and keeps a
// one-word value cache per DC; cmd_ready is low until each command completes.
module dc_mem_port
    import dc_mem_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic                                  cmd_reload,
    input  logic [CHOICE_WIDTH-1:0]               cmd_choice,
    input  logic [MAIN_ADDR_WIDTH-1:0]            cmd_reload_address,
    input  logic                                  cmd_write_out,
    input  logic [MAIN_ADDR_WIDTH-1:0]            cmd_write_address,
    input  logic [WORD_WIDTH-1:0]                 cmd_write_value,
    output logic                                  mem_req_valid,
    input  logic                                  mem_req_ready,
    output logic                                  mem_req_we,
    output logic [MAIN_ADDR_WIDTH-1:0]            mem_req_addr,
    output logic [WORD_WIDTH-1:0]                 mem_req_wdata,
    input  logic                                  mem_resp_valid,
    input  logic [WORD_WIDTH-1:0]                 mem_resp_rdata,
    output logic [NUM_DCS-1:0][WORD_WIDTH-1:0]    dc_values,
    output logic [NUM_DCS-1:0]                    dc_valid
);

    dc_mem_state_t                       state;
    dc_mem_cmd_t                         cmd_c;
    logic [NUM_DCS-1:0][MAIN_ADDR_WIDTH-1:0] dc_addrs;
    logic                                q_reload;
    logic [CHOICE_WIDTH-1:0]             q_choice;
    logic [MAIN_ADDR_WIDTH-1:0]          q_reload_address;
    logic [NUM_DCS-1:0]                  fwd_mask_c;
    logic [NUM_DCS-1:0]                  reload_sel_c;
    logic [NUM_DCS-1:0]                  fwd_apply_c;

    assign cmd_c = '{
        reload:         cmd_reload,
        choice:         cmd_choice,
        reload_address: cmd_reload_address,
        write_out:      cmd_write_out,
        write_address:  cmd_write_address,
        write_value:    cmd_write_value
    };

    dc_forward_match u_fwd (
        .dc_valid      (dc_valid),
        .dc_addrs      (dc_addrs),
        .write_address (cmd_c.write_address),
        .fwd_mask_c    (fwd_mask_c)
    );

    // A DC being reloaded by the same command is invalidated, not forwarded into.
    assign reload_sel_c = cmd_c.reload ? (NUM_DCS'(1) << cmd_c.choice) : '0;
    assign fwd_apply_c  = cmd_c.write_out ? (fwd_mask_c & ~reload_sel_c) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cmd_ready        <= 1'b1;
            mem_req_valid    <= 1'b0;
            mem_req_we       <= 1'b0;
            mem_req_addr     <= '0;
            mem_req_wdata    <= '0;
            dc_values        <= '0;
            dc_valid         <= '0;
            dc_addrs         <= '0;
            q_reload         <= 1'b0;
            q_choice         <= '0;
            q_reload_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        q_reload         <= cmd_c.reload;
                        q_choice         <= cmd_c.choice;
                        q_reload_address <= cmd_c.reload_address;
                        for (int unsigned i = 0; i < NUM_DCS; i++) begin
                            if (fwd_apply_c[i]) begin
                                dc_values[i] <= cmd_c.write_value;
                            end
                        end
                        if (cmd_c.reload) begin
                            dc_valid[cmd_c.choice] <= 1'b0;
                            dc_addrs[cmd_c.choice] <= cmd_c.reload_address;
                        end
                        if (cmd_c.write_out) begin
                            state         <= WRITE_REQ;
                            cmd_ready     <= 1'b0;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= 1'b1;
                            mem_req_addr  <= cmd_c.write_address;
                            mem_req_wdata <= cmd_c.write_value;
                        end else if (cmd_c.reload) begin
                            state         <= READ_REQ;
                            cmd_ready     <= 1'b0;
                            mem_req_valid <= 1'b1;
                            mem_req_we    <= 1'b0;
                            mem_req_addr  <= cmd_c.reload_address;
                            mem_req_wdata <= '0;
                        end
                    end
                end
                // Store always drains before the reload read is issued.
                WRITE_REQ: begin
                    if (mem_req_ready) begin
                        if (q_reload) begin
                            state         <= READ_REQ;
                            mem_req_we    <= 1'b0;
                            mem_req_addr  <= q_reload_address;
                            mem_req_wdata <= '0;
                        end else begin
                            state         <= IDLE;
                            cmd_ready     <= 1'b1;
                            mem_req_valid <= 1'b0;
                            mem_req_we    <= 1'b0;
                        end
                    end
                end
                READ_REQ: begin
                    if (mem_req_ready) begin
                        state         <= READ_WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                READ_WAIT: begin
                    if (mem_resp_valid) begin
                        state               <= IDLE;
                        cmd_ready           <= 1'b1;
                        dc_values[q_choice] <= mem_resp_rdata;
                        dc_valid[q_choice]  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dc_mem_port.sv
// Directed bench for dc_mem_port: reload, write+reload, forwarding,
// back-pressure, reset during an outstanding read and a no-op command.
module tb_dc_mem_port;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_reload;
    logic [1:0]        cmd_choice;
    logic [15:0]       cmd_reload_address;
    logic              cmd_write_out;
    logic [15:0]       cmd_write_address;
    logic [31:0]       cmd_write_value;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [15:0]       mem_req_addr;
    logic [31:0]       mem_req_wdata;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_rdata;
    logic [3:0][31:0]  dc_values;
    logic [3:0]        dc_valid;

    int n_checks = 0;
    int n_fails  = 0;
    int n_handshakes = 0;
    int hs_before;

    dc_mem_port dut (
        .clk                (clk),
        .reset              (reset),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_reload         (cmd_reload),
        .cmd_choice         (cmd_choice),
        .cmd_reload_address (cmd_reload_address),
        .cmd_write_out      (cmd_write_out),
        .cmd_write_address  (cmd_write_address),
        .cmd_write_value    (cmd_write_value),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_we         (mem_req_we),
        .mem_req_addr       (mem_req_addr),
        .mem_req_wdata      (mem_req_wdata),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_rdata     (mem_resp_rdata),
        .dc_values          (dc_values),
        .dc_valid           (dc_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req_valid && mem_req_ready) n_handshakes++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic rl, input logic [1:0] ch, input logic [15:0] ra,
                           input logic wo, input logic [15:0] wa, input logic [31:0] wv);
        cmd_valid          = 1'b1;
        cmd_reload         = rl;
        cmd_choice         = ch;
        cmd_reload_address = ra;
        cmd_write_out      = wo;
        cmd_write_address  = wa;
        cmd_write_value    = wv;
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_reload = 1'b0; cmd_choice = 2'd0; cmd_reload_address = '0;
        cmd_write_out = 1'b0; cmd_write_address = '0; cmd_write_value = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        tick(); tick();

        // Reset state
        chk("rst_cmd_ready", 128'(cmd_ready), 128'(1'b1));
        chk("rst_req_valid", 128'(mem_req_valid), 128'(1'b0));
        chk("rst_req_addr", 128'(mem_req_addr), 128'(16'h0));
        chk("rst_dc_valid", 128'(dc_valid), 128'(4'h0));
        chk("rst_dc_values", 128'(dc_values), 128'(0));
        reset = 1'b0;
        tick();

        // Reload only: DC2 from 0x0010
        set_cmd(1'b1, 2'd2, 16'h0010, 1'b0, 16'h0, 32'h0);
        mem_req_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("rl_req_valid", 128'(mem_req_valid), 128'(1'b1));
        chk("rl_req_we", 128'(mem_req_we), 128'(1'b0));
        chk("rl_req_addr", 128'(mem_req_addr), 128'(16'h0010));
        chk("rl_cmd_ready_busy", 128'(cmd_ready), 128'(1'b0));
        tick();
        chk("rl_req_dropped", 128'(mem_req_valid), 128'(1'b0));
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEADBEEF;
        tick();
        mem_resp_valid = 1'b0;
        chk("rl_dc2_value", 128'(dc_values[2]), 128'(32'hDEADBEEF));
        chk("rl_dc_valid", 128'(dc_valid), 128'(4'b0100));
        chk("rl_cmd_ready_back", 128'(cmd_ready), 128'(1'b1));

        // Write + reload of the same address into DC2
        set_cmd(1'b1, 2'd2, 16'h0020, 1'b1, 16'h0020, 32'h12345678);
        tick();
        cmd_valid = 1'b0;
        chk("wr_dc2_invalidated", 128'(dc_valid), 128'(4'b0000));
        chk("wr_req_valid", 128'(mem_req_valid), 128'(1'b1));
        chk("wr_req_we", 128'(mem_req_we), 128'(1'b1));
        chk("wr_req_addr", 128'(mem_req_addr), 128'(16'h0020));
        chk("wr_req_wdata", 128'(mem_req_wdata), 128'(32'h12345678));
        tick();
        chk("wr_then_read_valid", 128'(mem_req_valid), 128'(1'b1));
        chk("wr_then_read_we", 128'(mem_req_we), 128'(1'b0));
        chk("wr_then_read_addr", 128'(mem_req_addr), 128'(16'h0020));
        tick();
        chk("wr_read_done", 128'(mem_req_valid), 128'(1'b0));
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h12345678;
        tick();
        mem_resp_valid = 1'b0;
        chk("wr_dc2_value", 128'(dc_values[2]), 128'(32'h12345678));
        chk("wr_dc_valid", 128'(dc_valid), 128'(4'b0100));

        // Load DC1 with value 1 from 0x0030
        set_cmd(1'b1, 2'd1, 16'h0030, 1'b0, 16'h0, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1;
        tick();
        mem_resp_valid = 1'b0;
        chk("fw_setup_valid", 128'(dc_valid), 128'(4'b0110));
        chk("fw_setup_dc1", 128'(dc_values[1]), 128'(32'h1));

        // Write-only to 0x0030 forwards into DC1; memory then stalls 5 cycles
        mem_req_ready = 1'b0;
        set_cmd(1'b0, 2'd0, 16'h0, 1'b1, 16'h0030, 32'h55);
        tick();
        hs_before = n_handshakes;
        chk("fw_dc1", 128'(dc_values[1]), 128'(32'h55));
        chk("fw_dc0", 128'(dc_values[0]), 128'(32'h0));
        chk("fw_dc2", 128'(dc_values[2]), 128'(32'h12345678));
        chk("fw_dc3", 128'(dc_values[3]), 128'(32'h0));
        // A competing reload of DC1 is offered during the stall and must be ignored
        set_cmd(1'b1, 2'd1, 16'h0040, 1'b0, 16'h0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_req_valid", 128'(mem_req_valid), 128'(1'b1));
            chk("bp_req_we", 128'(mem_req_we), 128'(1'b1));
            chk("bp_req_addr", 128'(mem_req_addr), 128'(16'h0030));
            chk("bp_req_wdata", 128'(mem_req_wdata), 128'(32'h55));
            chk("bp_cmd_ready", 128'(cmd_ready), 128'(1'b0));
            tick();
        end
        cmd_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        chk("bp_req_released", 128'(mem_req_valid), 128'(1'b0));
        chk("bp_cmd_ready_back", 128'(cmd_ready), 128'(1'b1));
        chk("bp_one_handshake", 128'(n_handshakes - hs_before), 128'(1));
        chk("bp_dc_valid_kept", 128'(dc_valid), 128'(4'b0110));

        // No-op command
        set_cmd(1'b0, 2'd3, 16'h0077, 1'b0, 16'h0077, 32'hAA);
        tick();
        cmd_valid = 1'b0;
        chk("nop_req_valid", 128'(mem_req_valid), 128'(1'b0));
        chk("nop_cmd_ready", 128'(cmd_ready), 128'(1'b1));
        tick();
        chk("nop_req_valid_later", 128'(mem_req_valid), 128'(1'b0));
        chk("nop_dc_valid", 128'(dc_valid), 128'(4'b0110));

        // Reset while waiting for read data; the late response must be dropped
        set_cmd(1'b1, 2'd3, 16'h0050, 1'b0, 16'h0, 32'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("rw_waiting_ready", 128'(cmd_ready), 128'(1'b0));
        chk("rw_waiting_req", 128'(mem_req_valid), 128'(1'b0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hFFFF_FFFF;
        tick();
        mem_resp_valid = 1'b0;
        chk("rw_dc_valid", 128'(dc_valid), 128'(4'h0));
        chk("rw_dc_values", 128'(dc_values), 128'(0));
        chk("rw_cmd_ready", 128'(cmd_ready), 128'(1'b1));
        chk("rw_req_valid", 128'(mem_req_valid), 128'(1'b0));
        tick();
        chk("rw_dc_valid_later", 128'(dc_valid), 128'(4'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
